// File: rtl/control_input_conditioner_if.sv
// control_input_conditioner_if: raw pushbutton inputs and conditioned control outputs
interface control_input_conditioner_if;
    logic btn_pause_raw;
    logic btn_dir_raw;
    logic pause;
    logic up_down;
    logic pause_pulse;
    logic dir_pulse;

    modport master (
        output btn_pause_raw, btn_dir_raw,
        input  pause, up_down, pause_pulse, dir_pulse
    );

    modport slave (
        input  btn_pause_raw, btn_dir_raw,
        output pause, up_down, pause_pulse, dir_pulse
    );
endinterface

// File: rtl/control_input_conditioner.sv
// control_input_conditioner: synchronise, debounce and toggle the pause/direction pushbuttons.
// Optional macro INPUT_ACTIVE_LOW_EN treats the raw buttons as active-low; the synchroniser
// then resets to 1 (released) and its output is inverted, so the FSMs always see 1 = pressed.
module control_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    control_input_conditioner_if.slave  bus
);

    typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;

`ifdef INPUT_ACTIVE_LOW_EN
    localparam logic ACTIVE_LOW = 1'b1;
`else
    localparam logic ACTIVE_LOW = 1'b0;
`endif

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    // channel 0 = pause (resets to 0), channel 1 = up_down (resets to 1)
    localparam logic [1:0] LEVEL_RST = 2'b10;

    logic [1:0] raw;

    assign raw = {bus.btn_dir_raw, bus.btn_pause_raw};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [1:0]           sync;
        logic                 s;
        state_t               state, state_n;
        logic [CNT_WIDTH-1:0] cnt, cnt_n;
        logic                 press;
        logic                 pulse_q;
        logic                 level_q;

        assign s = sync[1] ^ ACTIVE_LOW;

        // two-flop synchroniser on the asynchronous raw button
        always_ff @(posedge clk) begin
            if (reset) sync <= {2{ACTIVE_LOW}};
            else       sync <= {sync[0], raw[c]};
        end

        // debounce state and stable-sample counter
        always_ff @(posedge clk) begin
            if (reset) begin
                state <= IDLE_LOW;
                cnt   <= '0;
            end else begin
                state <= state_n;
                cnt   <= cnt_n;
            end
        end

        // debounce next state; a press is the accepted WAIT_HIGH -> IDLE_HIGH transition
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            press   = 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (s) begin
                        state_n = WAIT_HIGH;
                        cnt_n   = CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state_n = IDLE_LOW;
                        cnt_n   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_n = IDLE_HIGH;
                        cnt_n   = '0;
                        press   = 1'b1;
                    end else begin
                        cnt_n   = cnt + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!s) begin
                        state_n = WAIT_LOW;
                        cnt_n   = CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state_n = IDLE_HIGH;
                        cnt_n   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_n = IDLE_LOW;
                        cnt_n   = '0;
                    end else begin
                        cnt_n   = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_n = IDLE_LOW;
                    cnt_n   = '0;
                end
            endcase
        end

        // registered press strobe and toggled level, both updated on the accepting edge
        always_ff @(posedge clk) begin
            if (reset) begin
                pulse_q <= 1'b0;
                level_q <= LEVEL_RST[c];
            end else begin
                pulse_q <= press;
                level_q <= level_q ^ press;
            end
        end
    end

    assign bus.pause       = g_ch[0].level_q;
    assign bus.pause_pulse = g_ch[0].pulse_q;
    assign bus.up_down     = g_ch[1].level_q;
    assign bus.dir_pulse   = g_ch[1].pulse_q;

endmodule

// File: tb/tb_control_input_conditioner.sv
// tb_control_input_conditioner: directed and random stimulus checked against a run-length debounce model
module tb_control_input_conditioner;

    localparam int D = 4;

`ifdef INPUT_ACTIVE_LOW_EN
    localparam logic AL = 1'b1;
`else
    localparam logic AL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    control_input_conditioner_if ifc();

    control_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cyc    = 0;
    int pcnt[2] = '{0, 0};
    int pcyc[2] = '{0, 0};

    // pressed-domain button levels (1 = pressed)
    logic btn[2] = '{1'b0, 1'b0};

    // model: two-sample delay line, debounced level, run length of disagreeing samples
    logic r1[2], r2[2], db[2], m_lvl[2], m_pul[2];
    int   run[2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(int ch, logic v);
        btn[ch] = v;
        if (ch == 0) ifc.btn_pause_raw = v ^ AL;
        else         ifc.btn_dir_raw   = v ^ AL;
    endtask

    function automatic void model_step();
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                r1[c] = 0; r2[c] = 0; db[c] = 0; run[c] = 0; m_pul[c] = 0;
                m_lvl[c] = (c == 1);
            end else begin
                logic s;
                s = r2[c];
                r2[c] = r1[c];
                r1[c] = btn[c];
                m_pul[c] = 0;
                if (s != db[c]) begin
                    run[c]++;
                    if (run[c] == D + 1) begin
                        db[c] = s;
                        run[c] = 0;
                        if (s) begin
                            m_pul[c] = 1;
                            m_lvl[c] = !m_lvl[c];
                        end
                    end
                end else run[c] = 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("pause", 32'(ifc.pause), 32'(m_lvl[0]));
        chk("up_down", 32'(ifc.up_down), 32'(m_lvl[1]));
        chk("pause_pulse", 32'(ifc.pause_pulse), 32'(m_pul[0]));
        chk("dir_pulse", 32'(ifc.dir_pulse), 32'(m_pul[1]));
        if (ifc.pause_pulse === 1'b1) begin pcnt[0]++; pcyc[0] = cyc; end
        if (ifc.dir_pulse === 1'b1) begin pcnt[1]++; pcyc[1] = cyc; end
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int c0, n0, n1;
        set_btn(0, 0);
        set_btn(1, 0);
        reset = 1'b1;
        ticks(2);
        chk("rst_pause", 32'(ifc.pause), 0);
        chk("rst_up_down", 32'(ifc.up_down), 1);
        chk("rst_pause_pulse", 32'(ifc.pause_pulse), 0);
        chk("rst_dir_pulse", 32'(ifc.dir_pulse), 0);
        reset = 1'b0;
        ticks(3);

        // clean pause press
        n0 = pcnt[0];
        set_btn(0, 1); c0 = cyc;
        ticks(20);
        chk("clean_pulses", pcnt[0] - n0, 1);
        chk("clean_latency", pcyc[0] - (c0 + 1), D + 2);
        chk("clean_pause", 32'(ifc.pause), 1);
        set_btn(0, 0);
        ticks(20);
        chk("release_no_pulse", pcnt[0] - n0, 1);
        set_btn(0, 1);
        ticks(20);
        chk("second_press_pause", 32'(ifc.pause), 0);
        set_btn(0, 0);
        ticks(20);

        // bouncing direction press
        n1 = pcnt[1];
        for (int i = 0; i < 4; i++) begin
            set_btn(1, (i % 2 == 0));
            ticks(2);
        end
        set_btn(1, 1); c0 = cyc;
        ticks(20);
        chk("bounce_pulses", pcnt[1] - n1, 1);
        chk("bounce_latency", pcyc[1] - (c0 + 1), D + 2);
        chk("bounce_up_down", 32'(ifc.up_down), 0);
        set_btn(1, 0);
        ticks(20);

        // long hold: one pulse, none on release
        n1 = pcnt[1];
        set_btn(1, 1);
        ticks(100);
        chk("hold_pulses", pcnt[1] - n1, 1);
        set_btn(1, 0);
        ticks(20);
        chk("hold_release_pulses", pcnt[1] - n1, 1);
        chk("hold_up_down", 32'(ifc.up_down), 1);

        // simultaneous presses
        n0 = pcnt[0]; n1 = pcnt[1];
        set_btn(0, 1); set_btn(1, 1);
        ticks(20);
        chk("simul_pause_pulses", pcnt[0] - n0, 1);
        chk("simul_dir_pulses", pcnt[1] - n1, 1);
        chk("simul_same_cycle", pcyc[0], pcyc[1]);
        chk("simul_pause", 32'(ifc.pause), 1);
        chk("simul_up_down", 32'(ifc.up_down), 0);
        set_btn(0, 0); set_btn(1, 0);
        ticks(20);

        // reset two cycles into WAIT_HIGH with the button still held
        n0 = pcnt[0];
        set_btn(0, 1);
        ticks(4);
        reset = 1'b1;
        ticks(2);
        chk("rstmid_no_pulse", pcnt[0] - n0, 0);
        chk("rstmid_pause", 32'(ifc.pause), 0);
        reset = 1'b0; c0 = cyc;
        ticks(12);
        chk("rstmid_pulses", pcnt[0] - n0, 1);
        chk("rstmid_latency", pcyc[0] - (c0 + 1), D + 2);
        chk("rstmid_pause_after", 32'(ifc.pause), 1);
        set_btn(0, 0);
        ticks(20);

        // random bouncing and occasional resets against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) set_btn(0, 1'($urandom_range(1)));
            if ($urandom_range(5) == 0) set_btn(1, 1'($urandom_range(1)));
            reset = ($urandom_range(150) == 0);
            tick();
        end
        reset = 1'b0;
        ticks(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
